// File: rtl/apb_arb_pkg.sv
// Shared types for the APB request arbiter: FSM states and the
// latched command bundle.
package apb_arb_pkg;

    // Upper bounds on the parameterised widths carried in cmd_t.
    localparam int MaxAddrW = 64;
    localparam int MaxDataW = 64;
    localparam int MaxProtW = 8;
    localparam int MaxIdxW  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [MaxAddrW-1:0] addr;
        logic [MaxDataW-1:0] wData;
        logic [MaxProtW-1:0] prot;
        logic                write;
        logic [MaxIdxW-1:0]  grant;
    } cmd_t;

endpackage

// File: rtl/apb_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap and
// advances the pointer past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            update,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic [IdxW-1:0] ptr
);

    // Lowest requester overall, then overridden by lowest at/above ptr.
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = IdxW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) grant_idx = IdxW'(i);
        end
    end

    always_comb begin
        grant = '0;
        if (|req) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (update && (|req)) begin
            if (grant_idx == IdxW'(N - 1)) ptr <= '0;
            else                           ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_request_arbiter.sv
// Shares one APB bridge port among ReqNum requesters: round-robin grant,
// address decode to selector lanes, SETUP/ACCESS sequencing and timeout.
module apb_request_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ReqNum        = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int ProtWidth     = 4,
    parameter int PrphNum       = 4,
    parameter int RegionBits    = 12,
    parameter int TimeoutCycles = 256
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ReqNum-1:0]                   reqValid,
    input  logic [ReqNum-1:0][AddrWidth-1:0]    reqAddr,
    input  logic [ReqNum-1:0]                   reqWrite,
    input  logic [ReqNum-1:0][DataWidth-1:0]    reqWData,
    input  logic [ReqNum-1:0][ProtWidth-1:0]    reqProt,
    output logic [ReqNum-1:0]                   reqReady,
    output logic [ReqNum-1:0]                   rspValid,
    output logic [DataWidth-1:0]                rspData,
    output logic                                rspErr,
    output logic [PrphNum-1:0]                  selectors,
    output logic [AddrWidth-1:0]                addr,
    output logic [ProtWidth-1:0]                prot,
    output logic                                write,
    output logic [DataWidth-1:0]                wData,
    output logic                                sel,
    output logic                                enable,
    input  logic                                ready,
    input  logic [DataWidth-1:0]                rData,
    input  logic                                subErr
);

    localparam int IdxW = (ReqNum > 1) ? $clog2(ReqNum) : 1;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int TLim = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [CntW-1:0]    TLimV   = CntW'(TLim);
    localparam logic [PrphNum-1:0] PrphOne = PrphNum'(1);
    localparam logic [ReqNum-1:0]  ReqOne  = ReqNum'(1);

    state_e              state;
    cmd_t                cmd;
    cmd_t                next_cmd;
    logic [CntW-1:0]     cnt;
    logic [ReqNum-1:0]   grant;
    logic [IdxW-1:0]     gidx;
    logic [IdxW-1:0]     ptr;
    logic                in_idle;
    logic [AddrWidth-1:0] win_addr;
    logic [AddrWidth-1:0] idx;
    logic                dec_ok;
    logic [PrphNum-1:0]  sel_hot;
    logic [ReqNum-1:0]   rsp_hot;
    logic                tmo;
    logic                unused_cmd;

    assign in_idle = (state == IDLE);

    rr_arbiter #(
        .N    (ReqNum),
        .IdxW (IdxW)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (reqValid),
        .update    (in_idle),
        .grant     (grant),
        .grant_idx (gidx),
        .ptr       (ptr)
    );

    assign reqReady = in_idle ? grant : '0;

    assign win_addr = reqAddr[gidx];
    assign idx      = win_addr >> RegionBits;
    assign dec_ok   = (idx < AddrWidth'(PrphNum));
    assign sel_hot  = PrphOne << idx;

    always_comb begin
        next_cmd = '0;
        next_cmd.addr[AddrWidth-1:0]  = win_addr;
        next_cmd.wData[DataWidth-1:0] = reqWData[gidx];
        next_cmd.prot[ProtWidth-1:0]  = reqProt[gidx];
        next_cmd.write                = reqWrite[gidx];
        next_cmd.grant[IdxW-1:0]      = gidx;
    end

    // The latched command doubles as the held APB address/data/prot/dir.
    assign addr  = cmd.addr[AddrWidth-1:0];
    assign wData = cmd.wData[DataWidth-1:0];
    assign prot  = cmd.prot[ProtWidth-1:0];
    assign write = cmd.write;

    assign rsp_hot    = ReqOne << cmd.grant[IdxW-1:0];
    assign tmo        = (TimeoutCycles != 0) && (cnt == TLimV);
    assign unused_cmd = ^{cmd, ptr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cnt       <= '0;
            sel       <= 1'b0;
            enable    <= 1'b0;
            selectors <= '0;
            rspValid  <= '0;
            rspErr    <= 1'b0;
            rspData   <= '0;
        end else begin
            rspValid <= '0;
            rspErr   <= 1'b0;
            rspData  <= '0;
            unique case (state)
                IDLE: begin
                    if (|reqValid) begin
                        if (dec_ok) begin
                            cmd       <= next_cmd;
                            state     <= SETUP;
                            sel       <= 1'b1;
                            selectors <= sel_hot;
                        end else begin
                            // Decode miss: answer at once, bus stays quiet.
                            rspValid <= grant;
                            rspErr   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state  <= ACCESS;
                    enable <= 1'b1;
                    cnt    <= '0;
                end
                ACCESS: begin
                    if (ready || tmo) begin
                        state     <= IDLE;
                        sel       <= 1'b0;
                        enable    <= 1'b0;
                        selectors <= '0;
                        rspValid  <= rsp_hot;
                        rspErr    <= ready ? subErr : 1'b1;
                        if (ready && !cmd.write) rspData <= rData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
